alu_control_seq: RTL

//  Front end of the ALU: decodes main-control ALU_Op plus R-type Funct into the 4-bit

---
 rtl/alu_pkg.sv | 79 +++++++
 rtl/mul_div_iter.sv | 60 ++++++
 rtl/alu_control_seq.sv | 96 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control front end: opcodes, funct fields,
// ALU control codes, FSM states and the decode helper.
package alu_pkg;

  localparam int MD_ITER_DEF = 32;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV = 6'h1A;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_XOR = 4'b0011;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_MULT = 4'b1000;
  localparam logic [3:0] CTL_DIV = 4'b1001;
  localparam logic [3:0] CTL_NOR = 4'b1100;
  localparam logic [3:0] CTL_SRL = 4'b1101;
  localparam logic [3:0] CTL_SLL = 4'b1111;

  typedef enum logic [1:0] {ST_IDLE, ST_MD_RUN, ST_MD_DONE} state_e;

  typedef struct packed {
    logic [3:0] code;
    logic       illegal;
  } dec_t;

  // Undefined opcodes/functs fall back to add so the ALU still sees a legal code.
  function automatic dec_t decode(input logic [2:0] op, input logic [5:0] fn);
    dec_t d;
    d.code = CTL_ADD;
    d.illegal = 1'b0;
    case (op)
      OP_ADD: d.code = CTL_ADD;
      OP_SUB: d.code = CTL_SUB;
      OP_AND: d.code = CTL_AND;
      OP_OR: d.code = CTL_OR;
      OP_XOR: d.code = CTL_XOR;
      OP_SLT: d.code = CTL_SLT;
      OP_RTYPE: begin
        case (fn)
          FN_ADD: d.code = CTL_ADD;
          FN_SUB: d.code = CTL_SUB;
          FN_AND: d.code = CTL_AND;
          FN_OR: d.code = CTL_OR;
          FN_XOR: d.code = CTL_XOR;
          FN_NOR: d.code = CTL_NOR;
          FN_SLT: d.code = CTL_SLT;
          FN_SLL: d.code = CTL_SLL;
          FN_SRL: d.code = CTL_SRL;
          FN_MULT: d.code = CTL_MULT;
          FN_DIV: d.code = CTL_DIV;
          default: d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// done_o marks the final iteration; result_o is valid alongside it.
module mul_div_iter #(
  parameter int WIDTH   = 32,
  parameter int MD_ITER = 32
) (
  input  logic             clk_i,
  input  logic             abort_i,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int CW = (MD_ITER > 1) ? $clog2(MD_ITER) : 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   m_q;
  logic [CW-1:0]      cnt_q;
  logic               run_q, div_q, bz_q;

  logic [WIDTH:0] sum, rem, diff, sel;
  logic           ge;
  logic           unused_sel_msb;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    rem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ge   = (rem >= {1'b0, m_q});
    diff = rem - {1'b0, m_q};
    sel  = ge ? diff : rem;
    if (div_q) acc_d = {sel[WIDTH-1:0], acc_q[WIDTH-2:0], ge};
    else       acc_d = {sum, acc_q[WIDTH-1:1]};
  end
  assign unused_sel_msb = sel[WIDTH];

  assign done_o   = run_q && (cnt_q == CW'(MD_ITER - 1));
  assign result_o = (div_q && bz_q) ? '1 : acc_d[WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (abort_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      div_q <= div_i;
      bz_q  <= (b_i == '0);
      m_q   <= div_i ? b_i : a_i;
      acc_q <= {{WIDTH{1'b0}}, (div_i ? a_i : b_i)};
    end else if (run_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control decode with registered outputs, plus a FSM that sequences
// multi-cycle multiply/divide through mul_div_iter.
module alu_control_seq
  import alu_pkg::*;
#(
  parameter int MD_ITER = MD_ITER_DEF,
  parameter int WIDTH   = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Valid_In,
  output logic             Ready_In,
  input  logic             Flush,
  input  logic [2:0]       ALU_Op,
  input  logic [5:0]       Funct,
  input  logic [4:0]       Shamt_In,
  input  logic [WIDTH-1:0] Operand_A,
  input  logic [WIDTH-1:0] Operand_B,
  output logic [3:0]       Control_ALU,
  output logic [4:0]       Shamt,
  output logic             Valid_Out,
  output logic             Use_MD,
  output logic [WIDTH-1:0] MD_Result,
  output logic             Stall,
  output logic             Illegal
);
  state_e           state_q;
  logic [3:0]       md_op_q;
  dec_t             dec;
  logic             is_md, accept, md_done;
  logic [WIDTH-1:0] md_res;

  assign dec      = decode(ALU_Op, Funct);
  assign is_md    = (dec.code == CTL_MULT) || (dec.code == CTL_DIV);
  assign Ready_In = (state_q == ST_IDLE);
  assign accept   = Valid_In && Ready_In && !Flush;

  mul_div_iter #(.WIDTH(WIDTH), .MD_ITER(MD_ITER)) u_md (
    .clk_i   (Clock),
    .abort_i (Reset || Flush),
    .start_i (accept && is_md),
    .div_i   (dec.code == CTL_DIV),
    .a_i     (Operand_A),
    .b_i     (Operand_B),
    .done_o  (md_done),
    .result_o(md_res)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      md_op_q     <= CTL_ADD;
      Control_ALU <= CTL_ADD;
      Shamt       <= '0;
      Valid_Out   <= 1'b0;
      Use_MD      <= 1'b0;
      MD_Result   <= '0;
      Stall       <= 1'b0;
      Illegal     <= 1'b0;
    end else begin
      Valid_Out <= 1'b0;
      Use_MD    <= 1'b0;
      Illegal   <= 1'b0;
      if (Flush) begin
        state_q <= ST_IDLE;
        Stall   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (accept) begin
            if (is_md) begin
              state_q <= ST_MD_RUN;
              md_op_q <= dec.code;
              Stall   <= 1'b1;
            end else begin
              Control_ALU <= dec.code;
              Shamt       <= (dec.code == CTL_SLL || dec.code == CTL_SRL) ? Shamt_In : '0;
              Valid_Out   <= 1'b1;
              Illegal     <= dec.illegal;
            end
          end
          ST_MD_RUN: if (md_done) begin
            state_q     <= ST_MD_DONE;
            Stall       <= 1'b0;
            Valid_Out   <= 1'b1;
            Use_MD      <= 1'b1;
            Control_ALU <= md_op_q;
            Shamt       <= '0;
            MD_Result   <= md_res;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
